// File: rtl/uart_pkg.sv
// Shared UART packet parameters and the packet-path state encoding.
package uart_pkg;

  localparam int unsigned PACKET_SIZE = 184;
  localparam int unsigned WORD_WIDTH  = 8;
  localparam int unsigned NUM_WORDS   = (PACKET_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;

  // Packet transfer phases; also used by the collector side.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/uart_packet_unbuffer.sv
// Splits one captured packet into MSB-first words for the UART transmitter
// over a valid/ready handshake; one packet in flight at a time.
module uart_packet_unbuffer #(
  parameter int unsigned PACKET_SIZE = uart_pkg::PACKET_SIZE,
  parameter int unsigned WORD_WIDTH  = uart_pkg::WORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PACKET_SIZE-1:0] sys_packet,
  input  logic                   abort,
  output logic [WORD_WIDTH-1:0]  uart_word,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   busy,
  output logic                   done
);

  import uart_pkg::*;

  localparam int unsigned NUM_WORDS = (PACKET_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned SR_W      = NUM_WORDS * WORD_WIDTH;
  localparam int unsigned PAD_W     = SR_W - PACKET_SIZE;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_e            state_q, state_d;
  logic [SR_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              word_valid_q, word_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              last_word;

  assign xfer      = word_valid_q & word_ready;
  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state selection; abort overrides every other condition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = SEND;
      SEND:    if (xfer && last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Next values of the shift register, word index and registered outputs.
  always_comb begin
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    word_valid_d = word_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    if (abort) begin
      idx_d        = '0;
      word_valid_d = 1'b0;
      busy_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          word_valid_d = 1'b0;
          busy_d       = 1'b0;
          if (load) begin
            // Left-align so the packet MSBs form word 0; unused low bits are zero.
            shreg_d      = SR_W'(sys_packet) << PAD_W;
            idx_d        = '0;
            word_valid_d = 1'b1;
            busy_d       = 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_word) begin
              word_valid_d = 1'b0;
              busy_d       = 1'b0;
              done_d       = 1'b1;
            end else begin
              shreg_d = shreg_q << WORD_WIDTH;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          word_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
        default: begin
          idx_d        = '0;
          word_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
      endcase
    end
  end

  assign uart_word  = shreg_q[SR_W-1 -: WORD_WIDTH];
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_packet_unbuffer.sv
// Directed/randomized bench for uart_packet_unbuffer at default size and at a
// 20-bit packet with 8-bit words.
module tb_uart_packet_unbuffer;

  localparam int unsigned PS  = 184;
  localparam int unsigned NW  = 23;
  localparam int unsigned SPS = 20;
  localparam int unsigned SNW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           load, abort, word_ready;
  logic [PS-1:0]  sys_packet;
  logic [7:0]     uart_word;
  logic           word_valid, busy, done;

  logic           s_load, s_abort, s_ready;
  logic [SPS-1:0] s_packet;
  logic [7:0]     s_word;
  logic           s_valid, s_busy, s_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_packet_unbuffer dut (
    .clk(clk), .rst(rst), .load(load), .sys_packet(sys_packet), .abort(abort),
    .uart_word(uart_word), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .done(done)
  );

  uart_packet_unbuffer #(.PACKET_SIZE(SPS), .WORD_WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .load(s_load), .sys_packet(s_packet), .abort(s_abort),
    .uart_word(s_word), .word_valid(s_valid), .word_ready(s_ready),
    .busy(s_busy), .done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: word k of a packet is the k-th WORD_WIDTH slice counted from the MSB.
  function automatic logic [7:0] ref_word(input logic [PS-1:0] pkt, input int k);
    logic [PS-1:0] t;
    t = pkt >> (8 * (NW - 1 - k));
    return t[7:0];
  endfunction

  function automatic logic [7:0] ref_word_s(input logic [SPS-1:0] pkt, input int k);
    logic [31:0] padded;
    padded = 32'(pkt) * 32'd16;
    return 8'((padded >> (8 * (SNW - 1 - k))) & 32'hFF);
  endfunction

  function automatic logic [PS-1:0] rand_packet();
    logic [PS-1:0] p;
    p = '0;
    for (int i = 0; i < NW; i++) p = {p[PS-9:0], 8'($urandom)};
    return p;
  endfunction

  // mode: 0 always ready, 1 five-cycle stall per word, 2 random ready.
  // noise_load: hold load high with junk packets while the packet is in flight.
  // abort_after: number of accepted words before abort (-1 for none).
  task automatic run_packet(input logic [PS-1:0] pkt, input int mode,
                            input bit noise_load, input int abort_after);
    int k = 0;
    int cycles = 0;
    int sc = 0;
    bit rdy;
    @(negedge clk);
    sys_packet = pkt;
    load = 1'b1;
    word_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    load = 1'b0;
    sys_packet = rand_packet();
    while (k < NW && cycles < 1000) begin
      check("valid", 32'(word_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("done_low", 32'(done), 32'd0);
      check($sformatf("word%0d", k), 32'(uart_word), 32'(ref_word(pkt, k)));
      if (abort_after >= 0 && k == abort_after) begin
        abort = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        word_ready = 1'b0;
        check("abort_valid", 32'(word_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
          word_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("abort_no_done", 32'(done), 32'd0);
          check("abort_idle_valid", 32'(word_valid), 32'd0);
        end
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: begin
          if (sc < 5) begin rdy = 1'b0; sc++; end
          else begin rdy = 1'b1; sc = 0; end
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      word_ready = rdy;
      if (noise_load) begin
        load = 1'b1;
        sys_packet = rand_packet();
      end
      @(negedge clk);
      if (rdy) k++;
      cycles++;
    end
    check("word_count", 32'(k), NW);
    check("done_pulse", 32'(done), 32'd1);
    check("end_valid", 32'(word_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    word_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    load = 1'b0;
    check("done_single", 32'(done), 32'd0);
    check("idle_valid", 32'(word_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_small(input logic [SPS-1:0] pkt, input bit rand_ready);
    int k = 0;
    int cycles = 0;
    bit rdy;
    @(negedge clk);
    s_packet = pkt;
    s_load = 1'b1;
    @(negedge clk);
    s_load = 1'b0;
    s_packet = 20'($urandom);
    while (k < SNW && cycles < 200) begin
      check("s_valid", 32'(s_valid), 32'd1);
      check($sformatf("s_word%0d", k), 32'(s_word), 32'(ref_word_s(pkt, k)));
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      s_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      cycles++;
    end
    check("s_word_count", 32'(k), SNW);
    check("s_done", 32'(s_done), 32'd1);
    check("s_end_valid", 32'(s_valid), 32'd0);
    @(negedge clk);
    check("s_done_single", 32'(s_done), 32'd0);
  endtask

  initial begin
    logic [PS-1:0] seq_pkt;
    logic [PS-1:0] pkt_a;

    rst = 1'b1;
    load = 1'b0; abort = 1'b0; word_ready = 1'b0; sys_packet = '0;
    s_load = 1'b0; s_abort = 1'b0; s_ready = 1'b0; s_packet = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_word", 32'(uart_word), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Idle with word_ready toggling: no activity
    for (int i = 0; i < 6; i++) begin
      word_ready = ~word_ready;
      @(negedge clk);
      check("idle_toggle_valid", 32'(word_valid), 32'd0);
      check("idle_toggle_busy", 32'(busy), 32'd0);
      check("idle_toggle_done", 32'(done), 32'd0);
    end

    // Bytes 0x01..0x17, MSB first, always ready
    seq_pkt = '0;
    for (int i = 1; i <= int'(NW); i++) seq_pkt = {seq_pkt[PS-9:0], 8'(i)};
    run_packet(seq_pkt, 0, 1'b0, -1);

    // Backpressure: five stall cycles before every transfer
    run_packet(rand_packet(), 1, 1'b0, -1);

    // load during SEND and DONE ignored, then a fresh packet starts cleanly
    pkt_a = rand_packet();
    run_packet(pkt_a, 2, 1'b1, -1);
    run_packet(rand_packet(), 0, 1'b0, -1);

    // Abort after 10 accepted words, then restart
    run_packet(rand_packet(), 0, 1'b0, 10);
    run_packet(rand_packet(), 2, 1'b0, -1);

    // Randomized packets and ready patterns
    for (int i = 0; i < 3; i++) run_packet(rand_packet(), 2, 1'($urandom_range(0, 1)), -1);

    // Reset mid-packet discards the packet immediately
    @(negedge clk);
    sys_packet = rand_packet();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    word_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_word", 32'(uart_word), 32'd0);
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    word_ready = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(word_valid), 32'd0);
    run_packet(rand_packet(), 0, 1'b0, -1);

    // Non-multiple packet size: 0xABCDE -> AB, CD, E0
    run_small(20'hABCDE, 1'b0);
    for (int i = 0; i < 3; i++) run_small(20'($urandom), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
